// File: rtl/mul_div_sequencer_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Holds the funct3 op encoding, the FSM state encoding and the iteration count.

package mul_div_sequencer_pkg;

    localparam int MULDIV_ITER = 32;
    localparam int CNT_W       = 5;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } MulDivOps;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } MulDivStates;

    // Two's-complement negate when neg is set.
    function automatic logic [31:0] negate_if32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] negate_if64(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/mul_div_sequencer_operand_prep.sv
// Operand preparation for the RV32M sequencer: converts operands to magnitudes
// according to the op's signedness, derives the result signs to be latched,
// and flags the divide special cases (divide by zero, signed overflow).

module MulDivOperandPrep
    import mul_div_sequencer_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] a_mag,
    output logic [31:0] b_mag,
    output logic        res_neg,
    output logic        rem_neg,
    output logic        div_zero,
    output logic        div_ovf
);

    logic     a_signed;
    logic     b_signed;
    logic     a_neg;
    logic     b_neg;
    MulDivOps op_e;

    // Decode signedness, build magnitudes and detect divide corner cases.
    always_comb begin
        op_e     = MulDivOps'(op);
        a_signed = (op_e == OP_MULH) || (op_e == OP_MULHSU) ||
                   (op_e == OP_DIV)  || (op_e == OP_REM);
        b_signed = (op_e == OP_MULH) || (op_e == OP_DIV) || (op_e == OP_REM);
        a_neg    = a_signed & rs1[31];
        b_neg    = b_signed & rs2[31];
        a_mag    = negate_if32(rs1, a_neg);
        b_mag    = negate_if32(rs2, b_neg);
        res_neg  = a_neg ^ b_neg;
        rem_neg  = a_neg;
        div_zero = op[2] && (rs2 == 32'd0);
        div_ovf  = op[2] && !op[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    end

endmodule

// File: rtl/mul_div_sequencer.sv
// RV32M multiply/divide sequencer: iterative shift-add multiplier and restoring
// divider, stalling the pipeline until a one-cycle result pulse on oValid.
// Build option: define MULDIV_FAST_MUL_EN to replace the iterative multiplier
// with a single-cycle 33x33 signed product (divides are unchanged).

module mul_div_sequencer
    import mul_div_sequencer_pkg::*;
(
    input  logic        iClk,
    input  logic        iRstN,
    input  logic        iStart,
    input  logic [2:0]  iOp,
    input  logic [31:0] iRs1Data,
    input  logic [31:0] iRs2Data,
    input  logic        iFlush,
    output logic        oStall,
    output logic        oBusy,
    output logic        oValid,
    output logic [31:0] oResult
);

    MulDivStates      state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic             res_neg_q, res_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      quo_q, quo_d;
    logic [31:0]      result_q, result_d;

    logic [31:0]      prep_a_mag;
    logic [31:0]      prep_b_mag;
    logic             prep_res_neg;
    logic             prep_rem_neg;
    logic             prep_div_zero;
    logic             prep_div_ovf;

    logic [31:0]      special_result;
    logic [32:0]      div_shifted;
    logic [32:0]      div_trial;
    logic             div_fits;
    logic [31:0]      rem_next;
    logic [31:0]      quo_next;
    logic [31:0]      div_out;

`ifdef MULDIV_FAST_MUL_EN
    logic             fast_a_sign;
    logic             fast_b_sign;
    logic signed [63:0] fast_a;
    logic signed [63:0] fast_b;
    logic [63:0]      fast_prod;
    logic [31:0]      fast_out;
`else
    logic [63:0]      acc_q, acc_d;
    logic [CNT_W-1:0] bit_idx;
    logic [63:0]      addend;
    logic [63:0]      acc_next;
    logic [63:0]      prod_signed;
    logic [31:0]      mul_out;
`endif

    MulDivOperandPrep u_prep (
        .op       (iOp),
        .rs1      (iRs1Data),
        .rs2      (iRs2Data),
        .a_mag    (prep_a_mag),
        .b_mag    (prep_b_mag),
        .res_neg  (prep_res_neg),
        .rem_neg  (prep_rem_neg),
        .div_zero (prep_div_zero),
        .div_ovf  (prep_div_ovf)
    );

    // Fixed results for divide-by-zero and signed overflow, chosen by quotient/remainder op.
    always_comb begin
        special_result = 32'd0;
        if (prep_div_zero) begin
            special_result = iOp[1] ? iRs1Data : 32'hFFFF_FFFF;
        end else if (prep_div_ovf) begin
            special_result = iOp[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // One restoring-divide step: bring in the next dividend bit MSB-first and trial-subtract.
    always_comb begin
        div_shifted = {rem_q, a_q[cnt_q]};
        div_trial   = div_shifted - {1'b0, b_q};
        div_fits    = ~div_trial[32];
        rem_next    = div_fits ? div_trial[31:0] : div_shifted[31:0];
        quo_next    = {quo_q[30:0], div_fits};
        case (MulDivOps'(op_q))
            OP_REM, OP_REMU: div_out = negate_if32(rem_next, rem_neg_q);
            default:         div_out = negate_if32(quo_next, res_neg_q);
        endcase
    end

`ifdef MULDIV_FAST_MUL_EN
    // Single-cycle signed product of sign/zero-extended operands.
    always_comb begin
        fast_a_sign = ((iOp == OP_MULH) || (iOp == OP_MULHSU)) & iRs1Data[31];
        fast_b_sign = (iOp == OP_MULH) & iRs2Data[31];
        fast_a      = {{32{fast_a_sign}}, iRs1Data};
        fast_b      = {{32{fast_b_sign}}, iRs2Data};
        fast_prod   = fast_a * fast_b;
        fast_out    = (iOp == OP_MUL) ? fast_prod[31:0] : fast_prod[63:32];
    end
`else
    // One shift-add step: add A shifted to the weight of the current multiplier bit.
    always_comb begin
        bit_idx     = CNT_W'(MULDIV_ITER - 1) - cnt_q;
        addend      = b_q[bit_idx] ? ({32'd0, a_q} << bit_idx) : 64'd0;
        acc_next    = acc_q + addend;
        prod_signed = negate_if64(acc_next, res_neg_q);
        mul_out     = (MulDivOps'(op_q) == OP_MUL) ? prod_signed[31:0] : prod_signed[63:32];
    end
`endif

    // Next-state and datapath update; a flush always returns to IDLE without a result.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        result_d  = result_q;
`ifndef MULDIV_FAST_MUL_EN
        acc_d     = acc_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (iStart && !iFlush) begin
                    op_d      = iOp;
                    a_d       = prep_a_mag;
                    b_d       = prep_b_mag;
                    res_neg_d = prep_res_neg;
                    rem_neg_d = prep_rem_neg;
                    cnt_d     = CNT_W'(MULDIV_ITER - 1);
                    rem_d     = 32'd0;
                    quo_d     = 32'd0;
`ifndef MULDIV_FAST_MUL_EN
                    acc_d     = 64'd0;
`endif
                    if (!iOp[2]) begin
`ifdef MULDIV_FAST_MUL_EN
                        result_d = fast_out;
                        state_d  = ST_DONE;
`else
                        state_d  = ST_MUL;
`endif
                    end else if (prep_div_zero || prep_div_ovf) begin
                        result_d = special_result;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_DIV;
                    end
                end
            end
`ifndef MULDIV_FAST_MUL_EN
            ST_MUL: begin
                acc_d = acc_next;
                if (cnt_q == '0) begin
                    result_d = mul_out;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            ST_DIV: begin
                rem_d = rem_next;
                quo_d = quo_next;
                if (cnt_q == '0) begin
                    result_d = div_out;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (iFlush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q   <= ST_IDLE;
            op_q      <= 3'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            result_q  <= 32'd0;
`ifndef MULDIV_FAST_MUL_EN
            acc_q     <= 64'd0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            result_q  <= result_d;
`ifndef MULDIV_FAST_MUL_EN
            acc_q     <= acc_d;
`endif
        end
    end

    // Pipeline handshake outputs decoded from state and the live start/flush inputs.
    always_comb begin
        oStall  = ((state_q == ST_IDLE) && iStart && !iFlush) ||
                  (state_q == ST_MUL) || (state_q == ST_DIV);
        oBusy   = (state_q == ST_MUL) || (state_q == ST_DIV);
        oValid  = (state_q == ST_DONE) && !iFlush;
        oResult = result_q;
    end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed and randomized bench for mul_div_sequencer with a result scoreboard
// and an independent arithmetic reference model for RV32M semantics.

module tb_mul_div_sequencer;
    import mul_div_sequencer_pkg::*;

    logic        iClk = 1'b0;
    logic        iRstN;
    logic        iStart;
    logic [2:0]  iOp;
    logic [31:0] iRs1Data;
    logic [31:0] iRs2Data;
    logic        iFlush;
    logic        oStall;
    logic        oBusy;
    logic        oValid;
    logic [31:0] oResult;

    typedef struct {
        string       tag;
        logic [31:0] value;
        int          latency;
    } exp_t;

    exp_t sb[$];
    int   testsRun    = 0;
    int   testsFailed = 0;

    mul_div_sequencer dut (
        .iClk     (iClk),
        .iRstN    (iRstN),
        .iStart   (iStart),
        .iOp      (iOp),
        .iRs1Data (iRs1Data),
        .iRs2Data (iRs2Data),
        .iFlush   (iFlush),
        .oStall   (oStall),
        .oBusy    (oBusy),
        .oValid   (oValid),
        .oResult  (oResult)
    );

    // Free-running clock.
    always #5 iClk = ~iClk;

    // RV32M reference semantics computed directly with wide arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        logic        [63:0] u;
        logic signed [31:0] sa;
        logic signed [31:0] sb2;
        logic               ovf;
        sa  = $signed(a);
        sb2 = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin u = {32'd0, a} * {32'd0, b}; return u[31:0]; end
            3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return p[63:32]; end
            3'd3: begin u = {32'd0, a} * {32'd0, b}; return u[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return $unsigned(sa / sb2);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                return $unsigned(sa % sb2);
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int expLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && ((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return 33;
    endfunction

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an op for one cycle, push its expected result and check the combinational stall.
    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        iStart   = 1'b1;
        iOp      = op;
        iRs1Data = a;
        iRs2Data = b;
        e.tag     = tag;
        e.value   = refModel(op, a, b);
        e.latency = expLatency(op, a, b);
        sb.push_back(e);
        #1;
        checkOutput({tag, "_stall_start"}, {31'd0, oStall}, 32'd1);
        tick();
        iStart   = 1'b0;
        iRs1Data = $urandom;
        iRs2Data = $urandom;
    endtask

    // Wait (bounded) for oValid, then pop the scoreboard and compare value, latency and stall.
    task automatic collectResult();
        exp_t e;
        int   cycles;
        logic stallOk;
        cycles  = 1;
        stallOk = 1'b1;
        while (!oValid && cycles < 100) begin
            if (!oStall || !oBusy) stallOk = 1'b0;
            tick();
            cycles++;
        end
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        if (!oValid) begin
            checkOutput({e.tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        checkOutput(e.tag, oResult, e.value);
        checkOutput({e.tag, "_latency"}, cycles, e.latency);
        checkOutput({e.tag, "_stall_done"}, {31'd0, oStall}, 32'd0);
        if (e.latency > 1) checkOutput({e.tag, "_stall_iter"}, {31'd0, stallOk}, 32'd1);
        tick();
        checkOutput({e.tag, "_valid_one_cycle"}, {31'd0, oValid}, 32'd0);
        checkOutput({e.tag, "_result_hold"}, oResult, e.value);
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        applyStimulus(tag, op, a, b);
        collectResult();
    endtask

    initial begin
        logic validSeen;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;

        iRstN    = 1'b0;
        iStart   = 1'b0;
        iOp      = 3'd0;
        iRs1Data = 32'd0;
        iRs2Data = 32'd0;
        iFlush   = 1'b0;
        tick();
        tick();
        checkOutput("reset_result", oResult, 32'd0);
        checkOutput("reset_valid", {31'd0, oValid}, 32'd0);
        checkOutput("reset_busy", {31'd0, oBusy}, 32'd0);
        checkOutput("reset_stall", {31'd0, oStall}, 32'd0);
        iRstN = 1'b1;
        tick();

        runOp("mul_7x6", 3'd0, 32'd7, 32'd6);
        runOp("mulh_min_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
        runOp("mulhu_max_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOp("mulhsu_m1_2", 3'd2, 32'hFFFF_FFFF, 32'd2);
        runOp("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
        runOp("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
        runOp("divu_100_7", 3'd5, 32'd100, 32'd7);
        runOp("remu_100_7", 3'd7, 32'd100, 32'd7);
        runOp("divu_5_0", 3'd5, 32'd5, 32'd0);
        runOp("rem_5_0", 3'd6, 32'd5, 32'd0);
        runOp("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        runOp("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Randomized ops against the reference model.
        for (int i = 0; i < 10; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            runOp($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
        end

        // Flush a DIV at N+10; expect IDLE at N+11 and no valid pulse.
        validSeen = 1'b0;
        iStart   = 1'b1;
        iOp      = 3'd4;
        iRs1Data = 32'd1000;
        iRs2Data = 32'd3;
        tick();
        iStart = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (oValid) validSeen = 1'b1;
            tick();
        end
        iFlush = 1'b1;
        #1;
        if (oValid) validSeen = 1'b1;
        tick();
        iFlush = 1'b0;
        #1;
        checkOutput("flush_busy", {31'd0, oBusy}, 32'd0);
        checkOutput("flush_stall", {31'd0, oStall}, 32'd0);
        if (oValid) validSeen = 1'b1;
        tick();
        runOp("mul_3x3_after_flush", 3'd0, 32'd3, 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (oValid) validSeen = 1'b1;
            tick();
        end
        checkOutput("flush_no_valid", {31'd0, validSeen}, 32'd0);

        // Async reset at N+5 of a DIV clears all outputs immediately.
        iStart   = 1'b1;
        iOp      = 3'd4;
        iRs1Data = 32'd12345;
        iRs2Data = 32'd17;
        tick();
        iStart = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        checkOutput("pre_reset_busy", {31'd0, oBusy}, 32'd1);
        iRstN = 1'b0;
        #1;
        checkOutput("async_reset_busy", {31'd0, oBusy}, 32'd0);
        checkOutput("async_reset_stall", {31'd0, oStall}, 32'd0);
        checkOutput("async_reset_valid", {31'd0, oValid}, 32'd0);
        checkOutput("async_reset_result", oResult, 32'd0);
        tick();
        iRstN = 1'b1;
        tick();
        iStart = 1'b1;
        iFlush = 1'b1;
        iOp    = 3'd0;
        #1;
        checkOutput("start_flush_stall", {31'd0, oStall}, 32'd0);
        tick();
        iStart = 1'b0;
        iFlush = 1'b0;
        #1;
        checkOutput("start_flush_busy", {31'd0, oBusy}, 32'd0);
        checkOutput("start_flush_stall_after", {31'd0, oStall}, 32'd0);
        tick();
        checkOutput("start_flush_valid", {31'd0, oValid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
